// File: rtl/cook_timer_ctrl.sv
// Microwave cook timer: keypad entry, mm:ss BCD countdown from 1 Hz tick,
// magnetron enable and done hold with auto-return to IDLE.
//
// Ports:
//   clk, rst_n            system clock, synchronous active-low reset
//   tick_1hz              1 Hz square wave; rising edges decrement in RUN
//   key_valid, key_digit  keypad BCD digit strobe
//   start, stop_clr       start/resume and pause/clear pulses
//   door_closed           interlock, 1 = closed
//   min_tens..sec_ones    remaining time, BCD mm:ss
//   state                 00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
//   mag_on, done          decoded from state
module cook_timer_ctrl #(
    parameter int QUICK_START_SEC = 30,
    parameter int DONE_TICKS      = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       stop_clr,
    input  logic       door_closed,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [1:0] state,
    output logic       mag_on,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    localparam logic [3:0] QS_T = 4'(QUICK_START_SEC / 10);
    localparam logic [3:0] QS_O = 4'(QUICK_START_SEC % 10);
    localparam logic [3:0] DT   = 4'(DONE_TICKS);

    state_t      r_state;
    logic [15:0] r_time;
    logic        r_tick_q;
    logic [3:0]  r_done_cnt;

    logic        w_tick_rise;
    logic [15:0] w_dec;
    logic        w_b0;
    logic        w_b1;
    logic        w_b2;
    logic        w_key_ok;
    logic [3:0]  w_cnt_nxt;

    assign w_tick_rise = tick_1hz & ~r_tick_q;
    assign w_key_ok    = key_valid && (key_digit <= 4'd9);
    assign w_cnt_nxt   = r_done_cnt + 4'd1;

    // One-second BCD decrement. Seconds tens is only reloaded to 5 on a
    // borrow, so entries above 59 simply count down linearly.
    always_comb begin
        w_dec = r_time;
        w_b0  = (r_time[3:0] == 4'd0);
        w_b1  = 1'b0;
        w_b2  = 1'b0;
        w_dec[3:0] = w_b0 ? 4'd9 : r_time[3:0] - 4'd1;
        if (w_b0) begin
            w_b1 = (r_time[7:4] == 4'd0);
            w_dec[7:4] = w_b1 ? 4'd5 : r_time[7:4] - 4'd1;
        end
        if (w_b1) begin
            w_b2 = (r_time[11:8] == 4'd0);
            w_dec[11:8] = w_b2 ? 4'd9 : r_time[11:8] - 4'd1;
        end
        if (w_b2) begin
            w_dec[15:12] = r_time[15:12] - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_time     <= 16'h0000;
            r_tick_q   <= 1'b0;
            r_done_cnt <= 4'd0;
        end else begin
            r_tick_q <= tick_1hz;
            unique case (r_state)
                S_IDLE: begin
                    if (stop_clr) begin
                        r_time <= 16'h0000;
                    end else if (start && door_closed) begin
                        if (r_time == 16'h0000) begin
                            r_time <= {8'h00, QS_T, QS_O};
                        end
                        r_state <= S_RUN;
                    end else if (w_key_ok) begin
                        r_time <= {r_time[11:0], key_digit};
                    end
                end
                S_RUN: begin
                    if (stop_clr || !door_closed) begin
                        r_state <= S_PAUSE;
                    end else if (w_tick_rise) begin
                        r_time <= w_dec;
                        if (w_dec == 16'h0000) begin
                            r_state    <= S_DONE;
                            r_done_cnt <= 4'd0;
                        end
                    end
                end
                S_PAUSE: begin
                    if (stop_clr) begin
                        r_state <= S_IDLE;
                        r_time  <= 16'h0000;
                    end else if (start && door_closed) begin
                        r_state <= S_RUN;
                    end
                end
                S_DONE: begin
                    if (stop_clr) begin
                        r_state <= S_IDLE;
                    end else if (w_tick_rise) begin
                        r_done_cnt <= w_cnt_nxt;
                        if (w_cnt_nxt == DT) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign {min_tens, min_ones, sec_tens, sec_ones} = r_time;
    assign state  = r_state;
    assign mag_on = (r_state == S_RUN);
    assign done   = (r_state == S_DONE);

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// Testbench for cook_timer_ctrl: table vectors plus multi-cycle sequences,
// expected outputs queued at drive time and compared after the clock edge.
module tb_cook_timer_ctrl;

    typedef struct packed {
        logic        rst_n;
        logic        tick;
        logic        kv;
        logic [3:0]  kd;
        logic        st;
        logic        sc;
        logic        door;
        logic [15:0] t;
        logic [1:0]  s;
    } vec_t;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] RUN   = 2'b01;
    localparam logic [1:0] PAUSE = 2'b10;
    localparam logic [1:0] DONE  = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       start = 1'b0;
    logic       stop_clr = 1'b0;
    logic       door_closed = 1'b1;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic [1:0] state;
    logic       mag_on, done;

    int checks = 0;
    int failures = 0;
    vec_t exp_q[$];

    cook_timer_ctrl #(.QUICK_START_SEC(30), .DONE_TICKS(3)) dut (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz),
        .key_valid(key_valid), .key_digit(key_digit),
        .start(start), .stop_clr(stop_clr), .door_closed(door_closed),
        .min_tens(min_tens), .min_ones(min_ones),
        .sec_tens(sec_tens), .sec_ones(sec_ones),
        .state(state), .mag_on(mag_on), .done(done)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic tk, logic kv, logic [3:0] kd,
                                logic st, logic sc, logic dr,
                                logic [15:0] t, logic [1:0] s);
        vec_t v;
        v.rst_n = r; v.tick = tk; v.kv = kv; v.kd = kd;
        v.st = st; v.sc = sc; v.door = dr; v.t = t; v.s = s;
        return v;
    endfunction

    function automatic logic [15:0] enc(int m, int s);
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic check(input string name);
        vec_t e;
        logic [15:0] act;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = exp_q.pop_front();
        act = {min_tens, min_ones, sec_tens, sec_ones};
        if (act !== e.t || state !== e.s || mag_on !== (e.s == RUN)
            || done !== (e.s == DONE)) begin
            failures++;
            $display("FAIL %s: got time=%h state=%b mag=%b done=%b, want time=%h state=%b mag=%b done=%b",
                     name, act, state, mag_on, done, e.t, e.s,
                     (e.s == RUN), (e.s == DONE));
        end
    endtask

    task automatic drive(input vec_t v, input string name);
        @(negedge clk);
        rst_n = v.rst_n; tick_1hz = v.tick; key_valid = v.kv;
        key_digit = v.kd; start = v.st; stop_clr = v.sc;
        door_closed = v.door;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        check(name);
    endtask

    task automatic key(input logic [3:0] d, input logic [15:0] t);
        drive(mk(1, 0, 1, d, 0, 0, 1, t, IDLE), "key");
    endtask

    // Counts down from m:s, one tick rise every 4 clocks; ends either by
    // riding out the done hold or by stop_clr while in DONE.
    task automatic run_down(input int m0, input int s0, input bit use_stop);
        int m = m0;
        int s = s0;
        while (m != 0 || s != 0) begin
            if (s > 0) s--;
            else begin s = 59; m--; end
            drive(mk(1, 1, 0, 0, 0, 0, 1, enc(m, s),
                     (m == 0 && s == 0) ? DONE : RUN), "dec");
            for (int j = 0; j < 3; j++)
                drive(mk(1, 0, 0, 0, 0, 0, 1, enc(m, s),
                         (m == 0 && s == 0) ? DONE : RUN), "hold");
        end
        if (use_stop) begin
            drive(mk(1, 0, 0, 0, 0, 1, 1, 16'h0000, IDLE), "done_stop");
        end else begin
            for (int k = 1; k <= 3; k++) begin
                drive(mk(1, 1, 0, 0, 1, 0, 0, 16'h0000,
                         (k < 3) ? DONE : IDLE), "done_tick");
                for (int j = 0; j < 3; j++)
                    drive(mk(1, 0, 0, 0, 0, 0, 1, 16'h0000,
                             (k < 3) ? DONE : IDLE), "done_hold");
            end
        end
    endtask

    vec_t tbl[29];

    initial begin
        tbl[0]  = mk(0, 0, 0, 0,  0, 0, 1, 16'h0000, IDLE);
        tbl[1]  = mk(0, 0, 0, 0,  0, 0, 1, 16'h0000, IDLE);
        tbl[2]  = mk(0, 0, 0, 0,  0, 0, 1, 16'h0000, IDLE);
        tbl[3]  = mk(1, 0, 1, 1,  0, 0, 1, 16'h0001, IDLE);
        tbl[4]  = mk(1, 0, 1, 3,  0, 0, 1, 16'h0013, IDLE);
        tbl[5]  = mk(1, 0, 1, 0,  0, 0, 1, 16'h0130, IDLE);
        tbl[6]  = mk(1, 0, 1, 12, 0, 0, 1, 16'h0130, IDLE);
        tbl[7]  = mk(1, 0, 0, 0,  0, 0, 1, 16'h0130, IDLE);
        tbl[8]  = mk(1, 0, 0, 0,  1, 1, 1, 16'h0000, IDLE);
        tbl[9]  = mk(1, 0, 0, 0,  1, 0, 1, 16'h0030, RUN);
        tbl[10] = mk(1, 0, 0, 0,  0, 1, 1, 16'h0030, PAUSE);
        tbl[11] = mk(1, 0, 1, 5,  0, 0, 1, 16'h0030, PAUSE);
        tbl[12] = mk(1, 0, 0, 0,  1, 0, 0, 16'h0030, PAUSE);
        tbl[13] = mk(1, 0, 0, 0,  1, 0, 1, 16'h0030, RUN);
        tbl[14] = mk(1, 0, 0, 0,  0, 0, 0, 16'h0030, PAUSE);
        tbl[15] = mk(1, 0, 0, 0,  0, 1, 1, 16'h0000, IDLE);
        tbl[16] = mk(1, 0, 1, 2,  0, 0, 1, 16'h0002, IDLE);
        tbl[17] = mk(1, 0, 1, 0,  0, 0, 1, 16'h0020, IDLE);
        tbl[18] = mk(1, 0, 1, 0,  0, 0, 1, 16'h0200, IDLE);
        tbl[19] = mk(1, 0, 0, 0,  1, 0, 1, 16'h0200, RUN);
        tbl[20] = mk(1, 0, 0, 0,  0, 1, 1, 16'h0200, PAUSE);
        tbl[21] = mk(1, 0, 0, 0,  0, 1, 1, 16'h0000, IDLE);
        tbl[22] = mk(1, 0, 0, 0,  1, 0, 0, 16'h0000, IDLE);
        tbl[23] = mk(1, 0, 1, 9,  0, 0, 1, 16'h0009, IDLE);
        tbl[24] = mk(1, 0, 1, 9,  0, 0, 1, 16'h0099, IDLE);
        tbl[25] = mk(1, 0, 1, 9,  0, 0, 1, 16'h0999, IDLE);
        tbl[26] = mk(1, 0, 1, 9,  0, 0, 1, 16'h9999, IDLE);
        tbl[27] = mk(1, 0, 0, 0,  1, 0, 1, 16'h9999, RUN);
        tbl[28] = mk(0, 0, 0, 0,  0, 0, 1, 16'h0000, IDLE);

        for (int i = 0; i < 29; i++) drive(tbl[i], $sformatf("vec%0d", i));

        // 01:00 countdown with minute borrow, done hold, auto-return
        key(1, 16'h0001);
        key(0, 16'h0010);
        key(0, 16'h0100);
        drive(mk(1, 0, 0, 0, 1, 0, 1, 16'h0100, RUN), "start_0100");
        run_down(1, 0, 0);

        // door opens on a tick rise: pause without decrement
        key(1, 16'h0001);
        key(0, 16'h0010);
        drive(mk(1, 0, 0, 0, 1, 0, 1, 16'h0010, RUN),   "start_0010");
        drive(mk(1, 1, 0, 0, 0, 0, 0, 16'h0010, PAUSE), "door_tick");
        drive(mk(1, 0, 0, 0, 0, 0, 0, 16'h0010, PAUSE), "door_open");
        drive(mk(1, 0, 0, 0, 1, 0, 0, 16'h0010, PAUSE), "start_open");
        drive(mk(1, 0, 0, 0, 0, 0, 1, 16'h0010, PAUSE), "door_shut");
        drive(mk(1, 0, 0, 0, 1, 0, 1, 16'h0010, RUN),   "resume");
        drive(mk(1, 1, 0, 0, 0, 0, 1, 16'h0009, RUN),   "dec_0009");
        drive(mk(1, 0, 0, 0, 0, 1, 1, 16'h0009, PAUSE), "stop1");
        drive(mk(1, 0, 0, 0, 0, 1, 1, 16'h0000, IDLE),  "stop2");

        // reset in the middle of RUN
        key(4, 16'h0004);
        key(5, 16'h0045);
        drive(mk(1, 0, 0, 0, 1, 0, 1, 16'h0045, RUN),  "start_0045");
        drive(mk(0, 0, 0, 0, 0, 0, 1, 16'h0000, IDLE), "rst_run");
        drive(mk(1, 0, 0, 0, 0, 0, 1, 16'h0000, IDLE), "post_rst");

        // over-range seconds count down linearly, then stop out of DONE
        key(7, 16'h0007);
        key(5, 16'h0075);
        drive(mk(1, 0, 0, 0, 1, 0, 1, 16'h0075, RUN), "start_0075");
        run_down(0, 75, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
